div32: RTL and testbench
========================

# div32

Iterative 32-bit integer divider that sits beside the single-cycle ALU in the execute stage. Where the ALU produces add/sub/logic/shift results in one cycle, this block performs the inverse of multiplication (DIV/DIVU) over 32 cycles using a start/busy/ready handshake. The CPU control stalls on `busy` and captures `q`/`r` on `ready`.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division. Sampled only when not busy.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `a`  in  32  dividend. Sampled with `start`.
- `b`  in  32  divisor. Sampled with `start`.
- `q`  out  32  quotient. Registered; held until the next result.
- `r`  out  32  remainder. Registered; held until the next result.
- `busy`  out  1  division in progress.
- `ready`  out  1  one-cycle pulse when `q`/`r` become valid.
- `dbz`  out  1  divide-by-zero flag. Valid with `ready`; held with `q`/`r`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - Latch |a| and |b|. Absolute values are taken only if `sign`=1.
  - Latch the result-sign bits: q negative = a[31]^b[31]; r negative = a[31]. Both are zero when unsigned.
  - Clear the 33-bit partial remainder and the 5-bit counter, then go to RUN.
- If b==0 at start:
  - Go to DONE on the next edge with no iterations.
  - Outputs: q=32'hFFFF_FFFF, r=a (raw, unmodified), dbz=1.
- RUN: one restoring step per cycle.
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial subtract the divisor (33-bit). If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Increment the counter. After the step with counter==31, go to DONE.
- Entering DONE:
  - Sign correction: two's complement of q and/or r where flagged.
  - Load `q`/`r`; dbz=0.
- Signed overflow 0x8000_0000 / -1 yields q=0x8000_0000, r=0. This is required behaviour, not flagged.
- Division truncates toward zero; the remainder takes the dividend's sign.
- DONE lasts one cycle, then returns to IDLE unless `start` is accepted in that cycle (back-to-back).
- `start` while in RUN is ignored; operand inputs are don't-care.

## Timing
- Reset values: q=0, r=0, busy=0, ready=0, dbz=0, state=IDLE.
- `start` sampled at edge E0:
  - `busy`=1 from after E0 through E32.
  - `ready`=1 for exactly the cycle after E32, which is the latency of 32 cycles.
  - `q`/`r`/`dbz` update at E32.
- Divide-by-zero: `ready` pulses after E1 (latency 1); `busy` is high only in the E0–E1 cycle.
- `busy` and `ready` are never high together.
- Reset mid-RUN: at the next edge, return to IDLE with all outputs at reset values. The in-flight result is discarded and no `ready` follows.
- Reset has priority over `start` in the same cycle.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: the `sign` input is honoured (abs/negate logic present).
  - Undefined: the `sign` port remains but is ignored; every operation is unsigned; the negation logic is removed.

## Structure
- Package `div_pkg`:
  - State enum (IDLE/RUN/DONE).
  - `DIV_WIDTH`=32 and `DIV_CNT_W`=5.
  - Divide-by-zero constant `DIV_DBZ_Q`=32'hFFFF_FFFF.
- Sub-module `div_step`: combinational 33-bit shift + trial-subtract + select. It returns the next partial remainder and the quotient bit and is instantiated once.

## Test plan
- Unsigned 100 / 7: `ready` exactly 32 cycles after `start`; q=14, r=2, dbz=0.
- Signed -7 / 2 (a=0xFFFF_FFF9): q=0xFFFF_FFFD, r=0xFFFF_FFFF. The same operands with `sign`=0 give q=0x7FFF_FFFC, r=1.
- a=0x1234, b=0: `ready` 1 cycle after `start`; q=0xFFFF_FFFF, r=0x1234, dbz=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF: q=0x8000_0000, r=0, dbz=0.
- `start` pulsed at cycle 5 of RUN with different operands is ignored and the first result is correct. A second `start` asserted in the DONE cycle produces its `ready` 32 cycles later.
- `reset` asserted at cycle 10 of RUN: the next cycle has busy=0, q=r=0, and no `ready` for 40 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM states,
// widths, the divide-by-zero quotient and a conditional negate helper.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    // Quotient reported when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV_DBZ_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's complement of v when en is set, v unchanged otherwise
    function automatic logic [DIV_WIDTH-1:0] div_neg(
        input logic [DIV_WIDTH-1:0] v,
        input logic                 en
    );
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, trial-subtract the divisor and keep the
// difference only when it is non-negative.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_i,
    input  logic                 msb_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH:0]   rem_o,
    output logic                 qbit_o
);

    // The remainder is always below the divisor, so the shifted value never
    // exceeds 33 bits; one extra bit keeps the trial sign unambiguous.
    logic [DIV_WIDTH+1:0] shifted;
    logic [DIV_WIDTH+1:0] diff;

    // Shift, trial subtract and select
    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {2'b00, divisor_i};
        qbit_o  = ~diff[DIV_WIDTH+1];
        rem_o   = qbit_o ? diff[DIV_WIDTH:0] : shifted[DIV_WIDTH:0];
    end

endmodule

// File: rtl/div32.sv
// Iterative 32-bit divider (DIV/DIVU) with start/busy/ready handshake.
// One quotient bit per cycle; result appears 32 cycles after start, or one
// cycle after start when the divisor is zero.
// Build option: define DIV_SIGNED_EN to honour the sign input; without it
// every operation is unsigned and the abs/negate logic is absent.
module div32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             dbz
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = '1;

    div_state_e             state_q, state_d;
    logic [DIV_WIDTH:0]     rem_q, rem_d;
    logic [DIV_WIDTH-1:0]   dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [DIV_WIDTH-1:0]   dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   zero_q, zero_d;   // divisor was zero at start
    logic [DIV_WIDTH-1:0]   q_q, q_d;
    logic [DIV_WIDTH-1:0]   r_q, r_d;
    logic                   dbz_q, dbz_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic [DIV_WIDTH:0]     step_rem;
    logic                   step_qbit;
    logic [DIV_WIDTH-1:0]   a_mag, b_mag;
    logic [DIV_WIDTH-1:0]   quo, res_q, res_r;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    assign a_neg = sign & a[DIV_WIDTH-1];
    assign b_neg = sign & b[DIV_WIDTH-1];
    assign a_mag = div_neg(a, a_neg);
    assign b_mag = div_neg(b, b_neg);
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign a_mag       = a;
    assign b_mag       = b;
`endif

    div_step u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[DIV_WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Final quotient/remainder of the last step, sign-corrected when enabled
    assign quo = {dvd_q[DIV_WIDTH-2:0], step_qbit};
`ifdef DIV_SIGNED_EN
    assign res_q = div_neg(quo, qneg_q);
    assign res_r = div_neg(step_rem[DIV_WIDTH-1:0], rneg_q);
`else
    assign res_q = quo;
    assign res_r = step_rem[DIV_WIDTH-1:0];
`endif

    // Next-state and datapath decode for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            RUN: begin
                if (zero_q) begin
                    // Divide by zero: report raw dividend, no iterations
                    state_d = DONE;
                    q_d     = DIV_DBZ_Q;
                    r_d     = dvd_q;
                    dbz_d   = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        q_d     = res_q;
                        r_d     = res_r;
                        dbz_d   = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new request
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    rem_d   = '0;
                    cnt_d   = '0;
                    zero_d  = (b == '0);
                    dvd_d   = (b == '0) ? a : a_mag;
                    dvs_d   = b_mag;
`ifdef DIV_SIGNED_EN
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                end
            end
        endcase
    end

    // State and output registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign q     = q_q;
    assign r     = r_q;
    assign dbz   = dbz_q;
    assign busy  = busy_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_div32.sv
// Directed testbench for div32: latency, results, divide by zero, signed
// overflow, ignored start during RUN, back-to-back start and mid-run reset.
module tb_div32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        ready;
    logic        dbz;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

`ifdef DIV_SIGNED_EN
    localparam logic [31:0] M7D2_Q  = 32'hFFFF_FFFD;
    localparam logic [31:0] M7D2_R  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q   = 32'h8000_0000;
    localparam logic [31:0] OVF_R   = 32'h0000_0000;
    localparam logic [31:0] P7DM2_Q = 32'hFFFF_FFFD;
    localparam logic [31:0] P7DM2_R = 32'h0000_0001;
`else
    localparam logic [31:0] M7D2_Q  = 32'h7FFF_FFFC;
    localparam logic [31:0] M7D2_R  = 32'h0000_0001;
    localparam logic [31:0] OVF_Q   = 32'h0000_0000;
    localparam logic [31:0] OVF_R   = 32'h8000_0000;
    localparam logic [31:0] P7DM2_Q = 32'h0000_0000;
    localparam logic [31:0] P7DM2_R = 32'h0000_0007;
`endif

    div32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns #1 after that edge
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        a = av; b = bv; sign = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until ready is seen (bounded), watching busy/ready overlap
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy && ready) overlap++;
        end while (!ready && n < 60);
    endtask

    // Full transaction: issue, wait, check latency and outputs
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic sv, input int lat,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int n;
        issue(av, bv, sv);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_ready(n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, edbz});
        $display("txn %s a=%h b=%h sign=%0d lat=%0d q=%h r=%h dbz=%0d", tag, av, bv, sv, n, q, r, dbz);
    endtask

    initial begin
        int n;
        int n2;
        int rdy_seen;
        reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);

        // Directed vectors
        run_div("u100d7",  32'd100,       32'd7,        1'b0, 32, 32'd14,        32'd2,      1'b0);
        run_div("sm7d2",   32'hFFFF_FFF9, 32'd2,        1'b1, 32, M7D2_Q,        M7D2_R,     1'b0);
        run_div("um7d2",   32'hFFFF_FFF9, 32'd2,        1'b0, 32, 32'h7FFF_FFFC, 32'd1,      1'b0);
        run_div("dbz",     32'h0000_1234, 32'd0,        1'b1, 1,  32'hFFFF_FFFF, 32'h1234,   1'b1);
        run_div("ovf",     32'h8000_0000, 32'hFFFF_FFFF,1'b1, 32, OVF_Q,         OVF_R,      1'b0);
        run_div("s7dm2",   32'd7,         32'hFFFF_FFFE,1'b1, 32, P7DM2_Q,       P7DM2_R,    1'b0);

        // start during RUN is ignored
        issue(32'd1000, 32'd10, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        issue(32'd77, 32'd5, 1'b0);
        wait_ready(n);
        check("ign_lat", n + 5, 32);
        check("ign_q", q, 32'd100);
        check("ign_r", r, 32'd0);
        $display("txn ignore_start lat=%0d q=%h r=%h", n + 5, q, r);

        // Back-to-back start in the DONE cycle
        issue(32'd77, 32'd5, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_noready", {31'd0, ready}, 32'd0);
        wait_ready(n2);
        check("b2b_lat", n2, 32);
        check("b2b_q", q, 32'd15);
        check("b2b_r", r, 32'd2);
        $display("txn back_to_back lat=%0d q=%h r=%h", n2, q, r);

        // Reset during RUN discards the result
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_q", q, 32'd0);
        check("mrst_r", r, 32'd0);
        check("mrst_ready", {31'd0, ready}, 32'd0);
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rdy_seen++;
        end
        check("mrst_no_ready", rdy_seen, 32'd0);
        $display("txn mid_run_reset busy=%0d q=%h r=%h ready_seen=%0d", busy, q, r, rdy_seen);

        check("busy_ready_overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
